// File: rtl/ifm_pingpong_ctrl.sv
// ifm_pingpong_ctrl
// Sequencing controller for a double-buffered IFM bank pair between two
// layers. The producer streams a full feature map into the write bank while
// the consumer reads the other bank. Once the write bank is full and the
// consumer has released the read bank, the banks swap and the next layer
// gets a start pulse. Pixel data never passes through this block; it only
// supplies the write strobe, the write address and the bank select.
module ifm_pingpong_ctrl #(
   parameter int IFM_SIZE         = 14,
   parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        prev_valid,
   output logic                        prev_ready,
   output logic                        ifm_enable_write_previous,
   output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous,
   output logic                        ifm_sel,
   output logic                        next_start,
   input  logic                        next_done,
   output logic                        read_bank_valid,
   output logic                        overflow_err,
   output logic                        underflow_err
);

   // Words per bank and the address of the final word of a map.
   localparam int                        N        = IFM_SIZE * IFM_SIZE;
   localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(N - 1);

   // Write side: filling the write bank, or holding a complete map that is
   // waiting for the read side to be released.
   typedef enum logic {
      WR_FILL = 1'b0,
      WR_FULL = 1'b1
   } wr_state_e;

   // Read side: no unreleased map, or the consumer is working on one.
   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BUSY = 1'b1
   } rd_state_e;

   wr_state_e                   wr_state_q, wr_state_d;
   rd_state_e                   rd_state_q, rd_state_d;
   logic [ADDRESS_SIZE_IFM-1:0] wr_cnt_q,   wr_cnt_d;
   logic                        sel_q,      sel_d;
   logic                        start_q,    start_d;
   logic                        ovf_q,      ovf_d;
   logic                        unf_q,      unf_d;

   logic accept;
   logic swap;

   // Handshake and swap decisions come from registered state only, so
   // next_done can never reach prev_ready or the write strobe combinationally.
   always_comb begin
      accept = 1'b0;
      swap   = 1'b0;
      swap   = (wr_state_q == WR_FULL) && (rd_state_q == RD_IDLE);
      accept = prev_valid && (wr_state_q == WR_FILL);
   end

   // Write FSM next state and write counter; the counter wraps to 0 on the
   // last word of a map and is held at 0 while the bank is full.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      unique case (wr_state_q)
         WR_FILL: begin
            if (accept) begin
               if (wr_cnt_q == LAST_ADDR) begin
                  wr_cnt_d   = '0;
                  wr_state_d = WR_FULL;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         WR_FULL: begin
            wr_cnt_d = '0;
            if (swap) begin
               wr_state_d = WR_FILL;
            end
         end
         default: begin
            wr_state_d = WR_FILL;
            wr_cnt_d   = '0;
         end
      endcase
   end

   // Read FSM next state. A done in the idle state has nothing to release,
   // so it is dropped here and only recorded as an underflow below.
   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (swap) begin
               rd_state_d = RD_BUSY;
            end
         end
         RD_BUSY: begin
            if (next_done) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: begin
            rd_state_d = RD_IDLE;
         end
      endcase
   end

   // Bank select, start pulse and sticky error flags.
   always_comb begin
      sel_d   = sel_q;
      start_d = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (swap) begin
         sel_d   = ~sel_q;
         start_d = 1'b1;
      end
      if (prev_valid && (wr_state_q != WR_FILL)) begin
         ovf_d = 1'b1;
      end
      if (next_done && (rd_state_q == RD_IDLE)) begin
         unf_d = 1'b1;
      end
   end

   // State registers; reset throws away all bookkeeping (bank contents are
   // left as they are and become meaningless).
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q <= WR_FILL;
         rd_state_q <= RD_IDLE;
         wr_cnt_q   <= '0;
         sel_q      <= 1'b0;
         start_q    <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_cnt_q   <= wr_cnt_d;
         sel_q      <= sel_d;
         start_q    <= start_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // The counter addresses a single bank and must stay inside it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (wr_cnt_q <= LAST_ADDR)
            else $error("write counter outside bank");
      end
   end

   // Output mapping.
   always_comb begin
      prev_ready                 = (wr_state_q == WR_FILL);
      ifm_enable_write_previous  = accept;
      ifm_address_write_previous = wr_cnt_q;
      ifm_sel                    = sel_q;
      next_start                 = start_q;
      read_bank_valid            = (rd_state_q == RD_BUSY);
      overflow_err               = ovf_q;
      underflow_err              = unf_q;
   end

endmodule

// File: tb/tb_ifm_pingpong_ctrl.sv
// tb_ifm_pingpong_ctrl
// Directed bench for the IFM ping-pong controller with IFM_SIZE=14 (N=196).
// Each cycle: inputs are driven 1 time unit after the rising edge and the
// outputs are sampled 1 time unit later, well away from the next edge.
module tb_ifm_pingpong_ctrl;

   localparam int IFM_SIZE = 14;
   localparam int N        = IFM_SIZE * IFM_SIZE;
   localparam int AW       = $clog2(N);

   logic          clk = 1'b0;
   logic          reset;
   logic          prev_valid;
   logic          prev_ready;
   logic          ifm_enable_write_previous;
   logic [AW-1:0] ifm_address_write_previous;
   logic          ifm_sel;
   logic          next_start;
   logic          next_done;
   logic          read_bank_valid;
   logic          overflow_err;
   logic          underflow_err;

   int passCount  = 0;
   int checkCount = 0;

   ifm_pingpong_ctrl #(
      .IFM_SIZE(IFM_SIZE)
   ) dut (
      .clk                       (clk),
      .reset                     (reset),
      .prev_valid                (prev_valid),
      .prev_ready                (prev_ready),
      .ifm_enable_write_previous (ifm_enable_write_previous),
      .ifm_address_write_previous(ifm_address_write_previous),
      .ifm_sel                   (ifm_sel),
      .next_start                (next_start),
      .next_done                 (next_done),
      .read_bank_valid           (read_bank_valid),
      .overflow_err              (overflow_err),
      .underflow_err             (underflow_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Stream `count` words; each word must be accepted at the expected address.
   // Optionally raise next_done in the cycle of the final word.
   task automatic fill_words(input string tag, input int count, input bit doneOnLast);
      for (int i = 0; i < count; i++) begin
         prev_valid = 1'b1;
         next_done  = doneOnLast && (i == count - 1);
         #1;
         checkCount++;
         if ({prev_ready, ifm_enable_write_previous, ifm_address_write_previous} !== {1'b1, 1'b1, AW'(i)})
            $display("[TB] FAIL %s word %0d: ready/en/addr got %b/%b/%0d expected 1/1/%0d",
                     tag, i, prev_ready, ifm_enable_write_previous, ifm_address_write_previous, i);
         else passCount++;
         step();
      end
      prev_valid = 1'b0;
      next_done  = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      prev_valid = 1'b0;
      next_done  = 1'b0;
      step();
      step();
      checkCount++;
      if ({ifm_sel, ifm_address_write_previous, prev_ready, next_start, read_bank_valid,
           overflow_err, underflow_err, ifm_enable_write_previous} !== {1'b0, AW'(0), 1'b1, 5'b0})
         $display("[TB] FAIL reset_values: sel=%b addr=%0d ready=%b start=%b rbv=%b ovf=%b unf=%b en=%b expected 0 0 1 0 0 0 0 0",
                  ifm_sel, ifm_address_write_previous, prev_ready, next_start, read_bank_valid,
                  overflow_err, underflow_err, ifm_enable_write_previous);
      else passCount++;
      reset = 1'b0;
   endtask

   task automatic test_first_fill();
      int starts;
      fill_words("first_fill", N, 1'b0);
      // T+1
      #1;
      checkCount++;
      if ({prev_ready, ifm_sel, next_start, read_bank_valid} !== 4'b0000)
         $display("[TB] FAIL first_fill_T1: ready/sel/start/rbv got %b%b%b%b expected 0000",
                  prev_ready, ifm_sel, next_start, read_bank_valid);
      else passCount++;
      step();
      // T+2
      checkCount++;
      if ({ifm_sel, next_start, prev_ready, read_bank_valid, ifm_address_write_previous} !== {4'b1111, AW'(0)})
         $display("[TB] FAIL first_fill_T2: sel/start/ready/rbv got %b%b%b%b addr %0d expected 1111 addr 0",
                  ifm_sel, next_start, prev_ready, read_bank_valid, ifm_address_write_previous);
      else passCount++;
      starts = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         starts += int'(next_start);
      end
      checkCount++;
      if ((starts !== 0) || (ifm_sel !== 1'b1))
         $display("[TB] FAIL first_fill_pulse_width: extra starts %0d sel %b expected 0 and 1", starts, ifm_sel);
      else passCount++;
   endtask

   task automatic test_withheld_done();
      fill_words("second_fill", N, 1'b0);
      // T+1: bank full, producer keeps pushing; no error yet (registered flag)
      prev_valid = 1'b1;
      #1;
      checkCount++;
      if ({prev_ready, ifm_enable_write_previous, overflow_err} !== 3'b000)
         $display("[TB] FAIL overflow_first_cycle: ready/en/ovf got %b%b%b expected 000",
                  prev_ready, ifm_enable_write_previous, overflow_err);
      else passCount++;
      step();
      for (int k = 0; k < 12; k++) begin
         prev_valid = (k < 6);
         #1;
         checkCount++;
         if ({prev_ready, ifm_enable_write_previous, ifm_sel, read_bank_valid, overflow_err, next_start,
              ifm_address_write_previous} !== {6'b001110, AW'(0)})
            $display("[TB] FAIL withheld_hold cycle %0d: ready/en/sel/rbv/ovf/start got %b%b%b%b%b%b addr %0d expected 001110 addr 0",
                     k, prev_ready, ifm_enable_write_previous, ifm_sel, read_bank_valid, overflow_err,
                     next_start, ifm_address_write_previous);
         else passCount++;
         step();
      end
      // Release the read bank for one cycle
      next_done = 1'b1;
      #1;
      checkCount++;
      if ({ifm_sel, next_start, prev_ready} !== 3'b100)
         $display("[TB] FAIL done_same_cycle: sel/start/ready got %b%b%b expected 100",
                  ifm_sel, next_start, prev_ready);
      else passCount++;
      step();
      next_done = 1'b0;
      #1;
      checkCount++;
      if ({ifm_sel, next_start, prev_ready, read_bank_valid} !== 4'b1000)
         $display("[TB] FAIL done_plus1: sel/start/ready/rbv got %b%b%b%b expected 1000",
                  ifm_sel, next_start, prev_ready, read_bank_valid);
      else passCount++;
      step();
      checkCount++;
      if ({ifm_sel, next_start, prev_ready, read_bank_valid, ifm_address_write_previous} !== {4'b0111, AW'(0)})
         $display("[TB] FAIL done_swap: sel/start/ready/rbv got %b%b%b%b addr %0d expected 0111 addr 0",
                  ifm_sel, next_start, prev_ready, read_bank_valid, ifm_address_write_previous);
      else passCount++;
      step();
      checkCount++;
      if ({next_start, overflow_err} !== 2'b01)
         $display("[TB] FAIL done_after_swap: start/ovf got %b%b expected 01", next_start, overflow_err);
      else passCount++;
   endtask

   task automatic test_underflow();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checkCount++;
      if ({overflow_err, read_bank_valid, ifm_sel} !== 3'b000)
         $display("[TB] FAIL underflow_pre_reset: ovf/rbv/sel got %b%b%b expected 000",
                  overflow_err, read_bank_valid, ifm_sel);
      else passCount++;
      step();
      next_done = 1'b1;
      step();
      next_done = 1'b0;
      #1;
      checkCount++;
      if ({underflow_err, ifm_sel, read_bank_valid, next_start, prev_ready} !== 5'b10001)
         $display("[TB] FAIL underflow: unf/sel/rbv/start/ready got %b%b%b%b%b expected 10001",
                  underflow_err, ifm_sel, read_bank_valid, next_start, prev_ready);
      else passCount++;
      step();
      step();
      checkCount++;
      if (underflow_err !== 1'b1)
         $display("[TB] FAIL underflow_sticky: got %b expected 1", underflow_err);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      int starts;
      fill_words("b2b_fill1", N, 1'b0);
      step();
      checkCount++;
      if ({ifm_sel, next_start, read_bank_valid} !== 3'b111)
         $display("[TB] FAIL b2b_first_swap: sel/start/rbv got %b%b%b expected 111",
                  ifm_sel, next_start, read_bank_valid);
      else passCount++;
      // Second map, consumer releases the bank with the last write
      fill_words("b2b_fill2", N, 1'b1);
      starts = 0;
      // T+1
      #1;
      starts += int'(next_start);
      checkCount++;
      if ({ifm_sel, read_bank_valid, prev_ready} !== 3'b100)
         $display("[TB] FAIL b2b_T1: sel/rbv/ready got %b%b%b expected 100",
                  ifm_sel, read_bank_valid, prev_ready);
      else passCount++;
      step();
      // T+2: swap visible; consumer finishes in the same cycle as the start
      next_done = 1'b1;
      #1;
      starts += int'(next_start);
      checkCount++;
      if ({ifm_sel, next_start, read_bank_valid, prev_ready} !== 4'b0111)
         $display("[TB] FAIL b2b_T2: sel/start/rbv/ready got %b%b%b%b expected 0111",
                  ifm_sel, next_start, read_bank_valid, prev_ready);
      else passCount++;
      step();
      next_done = 1'b0;
      #1;
      checkCount++;
      if ({read_bank_valid, ifm_sel} !== 2'b00)
         $display("[TB] FAIL done_with_start: rbv/sel got %b%b expected 00", read_bank_valid, ifm_sel);
      else passCount++;
      for (int k = 0; k < 4; k++) begin
         starts += int'(next_start);
         step();
      end
      checkCount++;
      if (starts !== 1)
         $display("[TB] FAIL b2b_start_count: got %0d expected 1", starts);
      else passCount++;
   endtask

   task automatic test_reset_midfill();
      fill_words("mid_fill1", N, 1'b0);
      step();
      checkCount++;
      if ({ifm_sel, read_bank_valid} !== 2'b11)
         $display("[TB] FAIL mid_pre_swap: sel/rbv got %b%b expected 11", ifm_sel, read_bank_valid);
      else passCount++;
      fill_words("mid_partial", 100, 1'b0);
      reset      = 1'b1;
      prev_valid = 1'b1;
      step();
      reset      = 1'b0;
      prev_valid = 1'b0;
      #1;
      checkCount++;
      if ({ifm_sel, ifm_address_write_previous, prev_ready, read_bank_valid, overflow_err, underflow_err, next_start}
          !== {1'b0, AW'(0), 1'b1, 4'b0000})
         $display("[TB] FAIL reset_midfill: sel=%b addr=%0d ready=%b rbv=%b ovf=%b unf=%b start=%b expected 0 0 1 0 0 0 0",
                  ifm_sel, ifm_address_write_previous, prev_ready, read_bank_valid, overflow_err,
                  underflow_err, next_start);
      else passCount++;
      fill_words("mid_refill", N, 1'b0);
      #1;
      checkCount++;
      if ({prev_ready, ifm_sel} !== 2'b00)
         $display("[TB] FAIL refill_T1: ready/sel got %b%b expected 00", prev_ready, ifm_sel);
      else passCount++;
      step();
      checkCount++;
      if ({ifm_sel, next_start, prev_ready, read_bank_valid} !== 4'b1111)
         $display("[TB] FAIL refill_swap: sel/start/ready/rbv got %b%b%b%b expected 1111",
                  ifm_sel, next_start, prev_ready, read_bank_valid);
      else passCount++;
   endtask

   // Scenarios run back to back; each leaves the state the next one expects.
   initial begin
      test_reset();
      test_first_fill();
      test_withheld_done();
      test_underflow();
      test_back_to_back();
      test_reset_midfill();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
